// File: rtl/matrix_index_counter.sv
// matrix_index_counter
// Walks a (row, column) matrix one element per increment between run-time limits.
// A run is opened by start, which latches the limits. Each increment advances the
// inner index. The final increment returns to IDLE and raises done for one cycle.
// Traversal order is fixed by ROW_MAJOR: 1 means column innermost, 0 means row innermost.
// Wrap-around uses an equality compare against the latched limit, so an all-ones limit
// uses the full index range and never depends on overflow.

module matrix_index_counter #(
  parameter int ROW_WIDTH = 2,
  parameter int COL_WIDTH = 2,
  parameter bit ROW_MAJOR = 1'b1
) (
  input  logic                 clock_i,
  input  logic                 clear_n_i,
  input  logic                 abort_i,
  input  logic                 start_i,
  input  logic [ROW_WIDTH-1:0] row_limit_i,
  input  logic [COL_WIDTH-1:0] col_limit_i,
  input  logic                 increment_i,
  output logic [ROW_WIDTH-1:0] row_index_o,
  output logic [COL_WIDTH-1:0] col_index_o,
  output logic                 busy_o,
  output logic                 last_row_o,
  output logic                 last_col_o,
  output logic                 last_value_o,
  output logic                 done_o
);

  localparam logic [ROW_WIDTH-1:0] ROW_STEP = ROW_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] COL_STEP = COL_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q,   state_d;
  logic [ROW_WIDTH-1:0]   row_q,     row_d;
  logic [COL_WIDTH-1:0]   col_q,     col_d;
  logic [ROW_WIDTH-1:0]   row_lim_q, row_lim_d;
  logic [COL_WIDTH-1:0]   col_lim_q, col_lim_d;
  logic                   done_q,    done_d;

  logic                   busy_s;
  logic                   row_at_lim_s;
  logic                   col_at_lim_s;
  logic                   last_value_s;

  assign busy_s       = (state_q == ST_RUN);
  assign row_at_lim_s = (row_q == row_lim_q);
  assign col_at_lim_s = (col_q == col_lim_q);
  assign last_value_s = busy_s & row_at_lim_s & col_at_lim_s;

  // Next-state logic: abort first, then start in IDLE, then increment in RUN.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    row_lim_d = row_lim_q;
    col_lim_d = col_lim_q;
    done_d    = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d   = ST_RUN;
            row_lim_d = row_limit_i;
            col_lim_d = col_limit_i;
            row_d     = '0;
            col_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!increment_i) begin
            state_d = ST_RUN;
          end else if (last_value_s) begin
            // Final element consumed: close the run and pulse done.
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            done_d  = 1'b1;
          end else if (ROW_MAJOR) begin
            if (col_at_lim_s) begin
              col_d = '0;
              row_d = row_q + ROW_STEP;
            end else begin
              col_d = col_q + COL_STEP;
            end
          end else begin
            if (row_at_lim_s) begin
              row_d = '0;
              col_d = col_q + COL_STEP;
            end else begin
              row_d = row_q + ROW_STEP;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          row_d   = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clock_i) begin
    if (!clear_n_i) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_lim_q <= '0;
      col_lim_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_lim_q <= row_lim_d;
      col_lim_q <= col_lim_d;
      done_q    <= done_d;
    end
  end

  assign row_index_o  = row_q;
  assign col_index_o  = col_q;
  assign busy_o       = busy_s;
  assign last_row_o   = busy_s & row_at_lim_s;
  assign last_col_o   = busy_s & col_at_lim_s;
  assign last_value_o = last_value_s;
  assign done_o       = done_q;

endmodule
